// File: rtl/castle_chaos_pkg.sv
// Shared definitions for the castle_chaos video path: pixel bus widths and
// the cell drawer state encoding. Imported by the game controller, the
// selector drawer and cell_sprite_drawer so that all agree on bus widths.
package castle_chaos_pkg;

   localparam int COLOUR_W = 3;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } draw_state_t;

endpackage

// File: rtl/pixel_scan_counter.sv
// Row-major scan of a CELL_SIZE x CELL_SIZE cell: col runs fastest, then row.
// Ports:
//   clk, reset  - clock, synchronous active-low reset
//   enable      - advance one pixel
//   clear       - synchronous return to offset (0,0), wins over enable
//   col, row    - current offset inside the cell
//   last        - current offset is the bottom-right pixel
module pixel_scan_counter #(
   parameter int CELL_SIZE = 16,
   localparam int CW = $clog2(CELL_SIZE)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          clear,
   output logic [CW-1:0] col,
   output logic [CW-1:0] row,
   output logic          last
);

   localparam logic [CW-1:0] MAX_OFF = CW'(CELL_SIZE - 1);

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         col <= '0;
         row <= '0;
      end else if (enable) begin
         if (col == MAX_OFF) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign last = (col == MAX_OFF) && (row == MAX_OFF);

endmodule

// File: rtl/cell_sprite_drawer.sv
// Draws one square board cell: a background of colour2 with an inset piece
// square of colour1, one pixel per cycle, then pulses done for one cycle.
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   load                - draw request, accepted only in IDLE
//   x, y                - top-left corner of the cell
//   colour1, colour2    - piece colour, background colour
//   x_out, y_out        - pixel coordinate to the VGA adapter
//   colour_out, plot    - pixel colour and write enable
//   done                - one-cycle completion pulse
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | waiting for load; outputs hold the last pixel
// ST_DRAW | one pixel per cycle presented with plot=1
// ST_DONE | single cycle with done=1, load ignored
module cell_sprite_drawer
   import castle_chaos_pkg::*;
#(
   parameter int CELL_SIZE    = 16,
   parameter int PIECE_MARGIN = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [X_W-1:0]      x,
   input  logic [Y_W-1:0]      y,
   input  logic [COLOUR_W-1:0] colour1,
   input  logic [COLOUR_W-1:0] colour2,
   output logic [X_W-1:0]      x_out,
   output logic [Y_W-1:0]      y_out,
   output logic [COLOUR_W-1:0] colour_out,
   output logic                plot,
   output logic                done
);

   localparam int CW = $clog2(CELL_SIZE);
   // One extra bit so CELL_SIZE - PIECE_MARGIN fits when the margin is 0.
   localparam logic [CW:0] M_LO = (CW+1)'(PIECE_MARGIN);
   localparam logic [CW:0] M_HI = (CW+1)'(CELL_SIZE - PIECE_MARGIN);

   draw_state_t state, state_next;

   logic [X_W-1:0]      x_lat;
   logic [Y_W-1:0]      y_lat;
   logic [COLOUR_W-1:0] c1_lat;
   logic [COLOUR_W-1:0] c2_lat;

   logic [CW-1:0] col;
   logic [CW-1:0] row;
   logic          last;
   logic          start;
   logic          scan_en;
   logic          in_piece;

   assign start   = (state == ST_IDLE) && load;
   assign scan_en = (state == ST_DRAW) && !last;

   pixel_scan_counter #(
      .CELL_SIZE (CELL_SIZE)
   ) u_scan (
      .clk    (clk),
      .reset  (reset),
      .enable (scan_en),
      .clear  (start),
      .col    (col),
      .row    (row),
      .last   (last)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (load) state_next = ST_DRAW;
         ST_DRAW: if (last) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         x_lat  <= '0;
         y_lat  <= '0;
         c1_lat <= '0;
         c2_lat <= '0;
      end else if (start) begin
         x_lat  <= x;
         y_lat  <= y;
         c1_lat <= colour1;
         c2_lat <= colour2;
      end
   end

   // Pixel outputs are pure functions of flops. The counter freezes on the
   // last pixel after DRAW, so coordinates and colour hold until the next
   // load, and read as zero after reset because every source is zero.
   assign in_piece = ({1'b0, col} >= M_LO) && ({1'b0, col} < M_HI) &&
                     ({1'b0, row} >= M_LO) && ({1'b0, row} < M_HI);

   assign x_out      = x_lat + X_W'(col);
   assign y_out      = y_lat + Y_W'(row);
   assign colour_out = in_piece ? c1_lat : c2_lat;
   assign plot       = (state == ST_DRAW);
   assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_cell_sprite_drawer.sv
module tb_cell_sprite_drawer;

   localparam int N = 16;
   localparam int M = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       load = 1'b0;
   logic [7:0] x = '0;
   logic [6:0] y = '0;
   logic [2:0] colour1 = '0;
   logic [2:0] colour2 = '0;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;
   logic       plot;
   logic       done;

   cell_sprite_drawer #(.CELL_SIZE(N), .PIECE_MARGIN(M)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .x          (x),
      .y          (y),
      .colour1    (colour1),
      .colour2    (colour2),
      .x_out      (x_out),
      .y_out      (y_out),
      .colour_out (colour_out),
      .plot       (plot),
      .done       (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference: each accepted request becomes a list of per-cycle output records.
   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic       plot;
      logic       done;
   } rec_t;

   rec_t q[$];
   rec_t cur = '0;
   bit   model_valid = 0;

   task automatic build(input logic [7:0] bx, input logic [6:0] by,
                        input logic [2:0] c1, input logic [2:0] c2);
      rec_t r;
      for (int rr = 0; rr < N; rr++) begin
         for (int cc = 0; cc < N; cc++) begin
            r.x    = 8'((int'(bx) + cc) % 256);
            r.y    = 7'((int'(by) + rr) % 128);
            r.c    = (cc >= M && cc < N - M && rr >= M && rr < N - M) ? c1 : c2;
            r.plot = 1'b1;
            r.done = 1'b0;
            q.push_back(r);
         end
      end
      r.plot = 1'b0;
      r.done = 1'b1;
      q.push_back(r);
   endtask

   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         q.delete();
         cur = '0;
         model_valid = 1;
      end else begin
         if (q.size() == 0 && !cur.done && load) build(x, y, colour1, colour2);
         if (q.size() > 0) begin
            cur = q.pop_front();
         end else begin
            cur.plot = 1'b0;
            cur.done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         checks++;
         if (x_out !== cur.x || y_out !== cur.y || colour_out !== cur.c ||
             plot !== cur.plot || done !== cur.done) begin
            failures++;
            $display("FAIL cycle_compare cyc=%0d actual x=%0d y=%0d c=%0d plot=%b done=%b required x=%0d y=%0d c=%0d plot=%b done=%b",
                     cyc, x_out, y_out, colour_out, plot, done,
                     cur.x, cur.y, cur.c, cur.plot, cur.done);
         end
      end
   end

   // Observation of DUT output for the literal checks.
   int         plots = 0;
   int         done_cnt = 0;
   int         last_plot_cyc = 0;
   int         done_cyc = 0;
   logic [7:0] first_x, last_x;
   logic [6:0] first_y, last_y;
   logic [2:0] c_20_36, c_19_36, c_first;

   always @(negedge clk) begin
      if (plot) begin
         plots++;
         if (plots == 1) begin
            first_x = x_out;
            first_y = y_out;
            c_first = colour_out;
         end
         last_x = x_out;
         last_y = y_out;
         last_plot_cyc = cyc;
         if (x_out == 8'd20 && y_out == 7'd36) c_20_36 = colour_out;
         if (x_out == 8'd19 && y_out == 7'd36) c_19_36 = colour_out;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic clear_mon();
      plots = 0;
      done_cnt = 0;
      c_20_36 = 'x;
      c_19_36 = 'x;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_load(input logic [7:0] bx, input logic [6:0] by,
                             input logic [2:0] c1, input logic [2:0] c2);
      x = bx; y = by; colour1 = c1; colour2 = c2;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic wait_done(input int target, input string name);
      int n = 0;
      while (done_cnt < target && n < 2000) begin
         step();
         n++;
      end
      if (done_cnt < target) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=%0d required=%0d", name, done_cnt, target);
      end
   endtask

   task automatic wait_plots(input int target, input string name);
      int n = 0;
      while (plots < target && n < 2000) begin
         step();
         n++;
      end
      if (plots < target) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=%0d required=%0d", name, plots, target);
      end
   endtask

   initial begin
      reset = 1'b0;
      load = 1'b1;   // must be ignored while in reset
      repeat (3) step();
      chk("reset_plot", int'(plot), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_xy", int'(x_out) + int'(y_out) + int'(colour_out), 0);
      load = 1'b0;
      reset = 1'b1;
      step();

      // Basic cell
      clear_mon();
      pulse_load(8'd16, 7'd32, 3'b111, 3'b001);
      wait_done(1, "basic");
      step();
      chk("basic_plots", plots, 256);
      chk("basic_first_x", int'(first_x), 16);
      chk("basic_first_y", int'(first_y), 32);
      chk("basic_last_x", int'(last_x), 31);
      chk("basic_last_y", int'(last_y), 47);
      chk("basic_piece_20_36", int'(c_20_36), 7);
      chk("basic_bg_19_36", int'(c_19_36), 1);
      chk("basic_done_after_last", done_cyc - last_plot_cyc, 1);
      chk("basic_done_count", done_cnt, 1);

      // Wrapping coordinates
      clear_mon();
      pulse_load(8'd248, 7'd120, 3'b010, 3'b101);
      wait_done(1, "wrap");
      step();
      chk("wrap_plots", plots, 256);
      chk("wrap_first_x", int'(first_x), 248);
      chk("wrap_first_y", int'(first_y), 120);
      chk("wrap_last_x", int'(last_x), 7);
      chk("wrap_last_y", int'(last_y), 7);

      // Load re-pulsed mid-draw with new values
      clear_mon();
      pulse_load(8'd40, 7'd10, 3'b100, 3'b011);
      wait_plots(100, "repulse");
      pulse_load(8'd200, 7'd90, 3'b000, 3'b110);
      wait_done(1, "repulse");
      step();
      chk("repulse_plots", plots, 256);
      chk("repulse_last_x", int'(last_x), 55);
      chk("repulse_last_y", int'(last_y), 25);
      chk("repulse_done_count", done_cnt, 1);

      // Reset mid-draw
      clear_mon();
      pulse_load(8'd64, 7'd64, 3'b110, 3'b010);
      wait_plots(50, "midreset");
      reset = 1'b0;
      step();
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("midreset_plot", int'(plot), 0);
      chk("midreset_done", int'(done), 0);
      chk("midreset_outputs", int'(x_out) + int'(y_out) + int'(colour_out), 0);
      repeat (300) step();
      chk("midreset_no_done", done_cnt, 0);
      clear_mon();
      pulse_load(8'd64, 7'd64, 3'b110, 3'b010);
      wait_done(1, "after_reset");
      step();
      chk("after_reset_plots", plots, 256);
      chk("after_reset_first_x", int'(first_x), 64);
      chk("after_reset_first_y", int'(first_y), 64);

      // Load held high: back-to-back drawings with one idle cycle between
      clear_mon();
      x = 8'd100; y = 7'd5; colour1 = 3'b011; colour2 = 3'b011;
      load = 1'b1;
      wait_done(3, "held");
      load = 1'b0;
      repeat (3) step();
      chk("held_plots", plots, 768);
      chk("uniform_colour", int'(c_first), 3);

      // Randomized requests with disturbing inputs mid-draw
      for (int it = 0; it < 10; it++) begin
         logic [2:0] c1r;
         int rst_at;
         c1r = 3'($urandom_range(0, 7));
         rst_at = (it % 4 == 3) ? int'($urandom_range(1, 259)) : -1;
         pulse_load(8'($urandom), 7'($urandom), c1r,
                    ($urandom_range(0, 3) == 0) ? c1r : 3'($urandom_range(0, 7)));
         for (int k = 0; k < 270; k++) begin
            x = 8'($urandom);
            y = 7'($urandom);
            colour1 = 3'($urandom_range(0, 7));
            colour2 = 3'($urandom_range(0, 7));
            load = ($urandom_range(0, 7) == 0);
            reset = (k == rst_at) ? 1'b0 : 1'b1;
            step();
         end
         load = 1'b0;
         reset = 1'b1;
         repeat (2) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
